// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a word-addressed SRAM with byte-lane strobes.
// Read and write channels have independent FSMs with programmable latency.
// Out-of-range addresses get SLVERR and never touch storage.
module axi_lite_sram_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1,
  parameter int WR_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  // AR channel
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  // R channel
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  // AW channel
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  // W channel
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  // B channel
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW  = $clog2(DEPTH_WORDS);
  localparam int RCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WCW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  localparam logic [29:0] WORD_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  // Storage
  logic [31:0] mem [DEPTH_WORDS];

  // Byte offset within a word carries no meaning for a 32-bit-only slave.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{araddr[1:0], awaddr[1:0]};

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t        r_state, r_next;
  logic [RCW-1:0]  r_cnt;
  logic [AW-1:0]   r_word;
  logic            r_ok;
  logic            ar_hs, r_hs, r_sample;

  assign ar_hs    = arvalid & arready;
  assign r_hs     = rvalid & rready;
  assign r_sample = (r_state == R_WAIT) && (r_cnt == '0);

  // Read FSM state register.
  // NOTE: clocked state uses non-blocking (<=) so every flop sees pre-edge values;
  // blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read FSM next-state logic.
  // NOTE: r_next gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)    r_next = R_WAIT;
      R_WAIT:  if (r_sample) r_next = R_RESP;
      R_RESP:  if (r_hs)     r_next = R_IDLE;
      default:               r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs; arready is forced low while reset is asserted.
  always_comb begin
    arready = (r_state == R_IDLE) && !rst;
    rvalid  = (r_state == R_RESP);
  end

  // Read datapath: latch address, run the latency counter, sample storage.
  // A same-edge write commit lands after this sample, so reads see old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_word <= '0;
      r_ok   <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_word <= araddr[AW+1:2];
        r_ok   <= (araddr[31:2] < WORD_LIMIT);
        r_cnt  <= RCW'(RD_LAT - 1);
      end else if ((r_state == R_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (r_sample) begin
        if (r_ok) begin
          rdata <= mem[r_word];
          rresp <= RESP_OKAY;
        end else begin
          rdata <= '0;
          rresp <= RESP_SLVERR;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t        w_state, w_next;
  logic [WCW-1:0]  w_cnt;
  logic            aw_done, w_done;
  logic [AW-1:0]   w_word;
  logic            w_ok;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;
  logic            aw_hs, wd_hs, b_hs, have_aw, have_w, w_commit;

  assign aw_hs    = awvalid & awready;
  assign wd_hs    = wvalid & wready;
  assign b_hs     = bvalid & bready;
  assign have_aw  = aw_done | aw_hs;
  assign have_w   = w_done | wd_hs;
  assign w_commit = (w_state == W_WAIT) && (w_cnt == '0);

  // Write FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write FSM next-state logic: leave idle once both halves are held.
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (have_aw && have_w) w_next = W_WAIT;
      W_WAIT:  if (w_commit)          w_next = W_RESP;
      W_RESP:  if (b_hs)              w_next = W_IDLE;
      default:                        w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs; each ready drops once its half has been captured.
  always_comb begin
    awready = (w_state == W_IDLE) && !aw_done && !rst;
    wready  = (w_state == W_IDLE) && !w_done  && !rst;
    bvalid  = (w_state == W_RESP);
  end

  // Write datapath: independent AW/W capture, latency counter, response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      w_word  <= '0;
      w_ok    <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      w_cnt   <= '0;
      bresp   <= RESP_OKAY;
    end else begin
      if (b_hs) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_done <= 1'b1;
          w_word  <= awaddr[AW+1:2];
          w_ok    <= (awaddr[31:2] < WORD_LIMIT);
        end
        if (wd_hs) begin
          w_done  <= 1'b1;
          wdata_q <= wdata;
          wstrb_q <= wstrb;
        end
      end

      if ((w_state == W_IDLE) && have_aw && have_w) begin
        w_cnt <= WCW'(WR_LAT - 1);
      end else if ((w_state == W_WAIT) && (w_cnt != '0)) begin
        w_cnt <= w_cnt - 1'b1;
      end

      if (w_commit) begin
        bresp <= w_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // Storage update: strobed byte lanes only, and only for in-range commits.
  // NOTE: the array has no reset; contents persist across rst, and a reset
  // port would also prevent mapping onto SRAM macros.
  always_ff @(posedge clk) begin
    if (w_commit && w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem[w_word][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
